// File: rtl/ebus_diag_pkg.sv
// Shared definitions for the EBUS diagnostic responder: ds field positions,
// responder state encoding and the 36-bit EBUS word type (bit 0 = MSB).
package ebus_diag_pkg;

  // ds[0] selects read, ds[1:3] is the board address, ds[4:6] the register
  localparam int DS_RD_BIT      = 0;
  localparam int DS_BOARD_FIRST = 1;
  localparam int DS_BOARD_LAST  = 3;
  localparam int DS_BANK_BIT    = 4;  // 1 = status bank (read-only)
  localparam int DS_REG_FIRST   = 5;
  localparam int DS_REG_LAST    = 6;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WRITE,
    READ,
    RELEASE,
    HOLD
  } tDiagRespState;

  typedef bit [0:35] tEbusWord;

  // Parity bit that makes the 37-bit group {w, p} contain an odd number of ones
  function automatic logic odd_parity(input logic [0:35] w);
    return ~(^w);
  endfunction

endpackage

// File: rtl/ebus_strobe_edge.sv
// Diag strobe edge detector: registers the strobe level and reports the
// rising and falling edges as single-cycle combinational pulses.
module ebus_strobe_edge (
  input  logic clk,
  input  logic i_rst,
  input  logic i_strobe,
  output logic o_rise,
  output logic o_fall
);

  logic r_strobe;

  // Previous-cycle strobe level; cleared by the board reset
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) r_strobe <= 1'b0;
    else       r_strobe <= i_strobe;
  end

  assign o_rise = i_strobe & ~r_strobe;
  assign o_fall = ~i_strobe & r_strobe;

endmodule

// File: rtl/ebus_diag_responder.sv
// EBUS diagnostic-function responder. Claims diag strobes addressed to
// BOARD_SEL, latches writes into four control registers and drives reads of
// control/status registers onto EBUS data until the strobe drops.
// Optional feature macro: EBUS_DIAG_PARITY_EN adds EBUS parity generation on
// reads and a sticky parity-error flag checked on writes.
module ebus_diag_responder
  import ebus_diag_pkg::*;
#(
  parameter logic [2:0] BOARD_SEL      = 3'o0,
  parameter int         SETTLE_CYCLES  = 2,
  parameter int         RELEASE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        CROBAR,
  input  logic [0:6]  ebus_ds,
  input  logic        ebus_diag_strobe,
  input  logic [0:35] ebus_data_in,
  output logic [0:35] ebus_data_out,
  output logic        ebus_driving,
  output logic [0:35] diag_regs [0:3],
  input  logic [0:35] status [0:3],
  output logic        wr_pulse,
  output logic [0:1]  wr_sel
`ifdef EBUS_DIAG_PARITY_EN
  ,
  input  logic        ebus_par_in,
  output logic        ebus_par_out,
  output logic        par_err
`endif
);

  tDiagRespState r_state, w_state_next;
  logic [2:0]    r_cnt, w_cnt_next;
  logic [0:6]    r_ds;
  tEbusWord      r_sample;
  logic          r_driving, w_driving_next;
  logic          r_wr_pulse;
  logic [0:1]    r_wr_sel;
  logic          w_rise, w_fall, w_claim;
  logic          w_ds_load, w_sample_load, w_do_write;
  logic [0:1]    w_reg_idx;
  logic [0:35]   w_rd_word;

  ebus_strobe_edge u_strobe_edge (
    .clk      (clk),
    .i_rst    (CROBAR),
    .i_strobe (ebus_diag_strobe),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );

  assign w_claim   = (ebus_ds[DS_BOARD_FIRST:DS_BOARD_LAST] == BOARD_SEL);
  assign w_reg_idx = r_ds[DS_REG_FIRST:DS_REG_LAST];

  // State register
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_driving_next = r_driving;
    w_ds_load      = 1'b0;
    w_sample_load  = 1'b0;
    w_do_write     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise && w_claim) begin
          w_ds_load = 1'b1;
          if (ebus_ds[DS_RD_BIT]) begin
            w_state_next   = READ;
            w_driving_next = 1'b1;
          end else begin
            w_state_next = SETTLE;
            w_cnt_next   = 3'(SETTLE_CYCLES - 1);
          end
        end
      end
      SETTLE: begin
        // A strobe drop before the data settles abandons the write
        if (w_fall) begin
          w_state_next = IDLE;
        end else if (r_cnt == 3'd0) begin
          w_sample_load = 1'b1;
          w_state_next  = WRITE;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      WRITE: begin
        // Status-bank indices are read-only; such writes vanish quietly
        w_do_write   = ~r_ds[DS_BANK_BIT];
        w_state_next = HOLD;
      end
      READ: begin
        if (w_fall) begin
          if (RELEASE_CYCLES == 0) begin
            w_driving_next = 1'b0;
            w_state_next   = IDLE;
          end else begin
            w_cnt_next   = 3'(RELEASE_CYCLES - 1);
            w_state_next = RELEASE;
          end
        end
      end
      RELEASE: begin
        // Strobe activity here is ignored; a rise during release is lost
        if (r_cnt == 3'd0) begin
          w_driving_next = 1'b0;
          w_state_next   = IDLE;
        end else begin
          w_cnt_next = r_cnt - 3'd1;
        end
      end
      HOLD: begin
        if (!ebus_diag_strobe) w_state_next = IDLE;
      end
      default: begin
        w_state_next   = IDLE;
        w_driving_next = 1'b0;
      end
    endcase
  end

  // Transaction capture: ds on the claimed rise, data at the end of settle
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_cnt      <= 3'd0;
      r_ds       <= 7'd0;
      r_sample   <= '0;
      r_driving  <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_sel   <= 2'd0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_driving  <= w_driving_next;
      r_wr_pulse <= w_do_write;
      if (w_ds_load)     r_ds     <= ebus_ds;
      if (w_sample_load) r_sample <= ebus_data_in;
      if (w_do_write)    r_wr_sel <= w_reg_idx;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ctl_reg
      tEbusWord r_reg;
      // Control register gi: loaded from the settled sample by a claimed write
      always_ff @(posedge clk or posedge CROBAR) begin
        if (CROBAR)                                r_reg <= '0;
        else if (w_do_write && w_reg_idx == 2'(gi)) r_reg <= r_sample;
      end
      assign diag_regs[gi] = r_reg;
    end
  endgenerate

  // Read data follows the selected register live for as long as we drive
  assign w_rd_word     = r_ds[DS_BANK_BIT] ? status[w_reg_idx] : diag_regs[w_reg_idx];
  assign ebus_data_out = r_driving ? w_rd_word : 36'd0;
  assign ebus_driving  = r_driving;
  assign wr_pulse      = r_wr_pulse;
  assign wr_sel        = r_wr_sel;

`ifdef EBUS_DIAG_PARITY_EN
  logic r_par_sample, r_par_err;
  logic w_par_bad, w_par_clear;

  // The sampled group must carry odd parity; an even count is an error
  assign w_par_bad   = ~(^{r_sample, r_par_sample});
  // Writing register 3 with bit 0 set is the software clear of the flag
  assign w_par_clear = w_do_write && (w_reg_idx == 2'd3) && r_sample[0];

  // Parity bit captured with the data, and the sticky error flag
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      r_par_sample <= 1'b0;
      r_par_err    <= 1'b0;
    end else begin
      if (w_sample_load) r_par_sample <= ebus_par_in;
      if (w_par_clear)                             r_par_err <= 1'b0;
      else if ((r_state == WRITE) && w_par_bad)    r_par_err <= 1'b1;
    end
  end

  assign ebus_par_out = r_driving ? odd_parity(ebus_data_out) : 1'b0;
  assign par_err      = r_par_err;
`endif

endmodule
